ex_mem_skid_stage: RTL
======================

// Module: ex_mem_skid_stage
// PURPOSE
//  Parametrised EX->MEM pipeline stage. Carries the register-writeback and HI/LO-writeback payloads.
//  Adds valid/ready handshake, synchronous flush and an optional 2-entry skid buffer, so a MEM-side
//  stall never drops or duplicates an EX result. in_ready is registered when SKID_EN=1.
//  Sits between the EX stage outputs and the MEM stage inputs of the 5-stage MIPS pipeline.
// PARAMETERS
//  WREG_W   38  packed width of the register writeback bundle (we[37], addr[36:32], data[31:0])
//  HILO_W   65  packed width of the HI/LO writeback bundle (we[64], hi[63:32], lo[31:0])
//  SKID_EN  1   1: two-entry skid, in_ready registered; 0: single register, in_ready combinational
//  CNT_W    16  width of the saturating stall-cycle counter
// PORTS
//  clk         in   1        pipeline clock, all state on rising edge
//  rst         in   1        asynchronous, active-low reset (asserted at 0)
//  flush       in   1        synchronous kill of all held entries (exception/branch squash)
//  in_valid    in   1        EX presents a valid result
//  in_ready    out  1        stage can accept this cycle
//  ex_wreg_i   in   WREG_W   register writeback payload from EX
//  ex_hilo_i   in   HILO_W   HI/LO writeback payload from EX
//  out_valid   out  1        MEM-facing entry valid
//  out_ready   in   1        MEM consumes this cycle
//  mem_wreg_o  out  WREG_W   register writeback payload to MEM
//  mem_hilo_o  out  HILO_W   HI/LO writeback payload to MEM
//  stall_cnt_o out  CNT_W    cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//  Reset (async, rst=0): out_valid=0, skid empty, in_ready=1, mem_wreg_o=0, mem_hilo_o=0, stall_cnt_o=0.
//  Handshakes: accept = in_valid & in_ready; deliver = out_valid & out_ready. Payload is stable while
//   out_valid & !out_ready. Order is strictly FIFO. Latency is 1 cycle: data accepted at edge N is
//   visible at mem_*_o after edge N.
//  Bubble rule: when out_valid=0, mem_wreg_o and mem_hilo_o are all-zero, so both we bits are 0 and
//   MEM never writes on a bubble.
//  SKID_EN=1 FSM (main=output reg, skid=spare reg), in_ready = (state!=FULL2), registered:
//   EMPTY: accept -> ONE (main<=in).
//   ONE:   accept&deliver -> ONE (main<=in); accept&!deliver -> FULL2 (skid<=in);
//          !accept&deliver -> EMPTY (main<=0); else hold.
//   FULL2: in_ready=0. deliver -> ONE (main<=skid, skid<=0); else hold.
//  SKID_EN=0: single reg. in_ready = !out_valid | out_ready (combinational).
//   accept loads main; deliver without accept clears it.
//  Flush: flush=1 at an edge -> state EMPTY, all payload regs zeroed, in_ready=1 next cycle.
//   Flush beats a simultaneous accept; the EX entry is dropped. A deliver in the same cycle still
//   counts as delivered to MEM.
//  stall_cnt_o: +1 each cycle out_valid & !out_ready. Saturates at 2^CNT_W-1, no wrap.
//   Unaffected by flush; cleared only by reset.
//  Reset mid-operation: all entries discarded immediately (async), no partial delivery.
//  in_valid=0 cycles never change held data. in_valid while in_ready=0 is ignored and not latched;
//   EX must hold its payload.
// TESTING
//  1 Reset: rst=0 mid-stream with FULL2 -> out_valid=0, in_ready=1, payloads 0, stall_cnt_o=0 immediately.
//  2 Streaming: out_ready=1, 8 back-to-back accepts wdata=1..8 -> mem_wreg_o data 1..8 on consecutive
//    cycles, 1-cycle latency, no gaps.
//  3 Stall: accept A=0xA, B=0xB, then out_ready=0 for 4 cycles with in_valid=1 (C=0xC) -> in_ready=0
//    after B; A held 4 cycles; stall_cnt_o=4; release -> A, B, C in order, C accepted exactly once.
//  4 Flush: FULL2 holding A,B plus in_valid (C) with flush=1 -> next cycle out_valid=0, payloads 0,
//    in_ready=1; A/B/C never appear.
//  5 HI/LO: accept hilo={we=1,hi=0xDEADBEEF,lo=0x12345678} -> mem_hilo_o equal next cycle; after
//    deliver with no accept -> mem_hilo_o=0.
//  6 SKID_EN=0 and CNT_W=4: out_ready=0 for 20 cycles -> in_ready=!out_valid|out_ready combinationally;
//    stall_cnt_o saturates at 15.

Source files
------------

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline register with valid/ready handshake, synchronous flush and
// optional two-entry skid buffer; zero payload on bubbles, saturating stall counter.
module ex_mem_skid_stage #(
  parameter int WREG_W  = 38,
  parameter int HILO_W  = 65,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WREG_W-1:0] ex_wreg_i,
  input  logic [HILO_W-1:0] ex_hilo_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WREG_W-1:0] mem_wreg_o,
  output logic [HILO_W-1:0] mem_hilo_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int PW = WREG_W + HILO_W;

  logic [PW-1:0] in_pl;
  logic [PW-1:0] out_pl;
  logic          accept;
  logic          deliver;

  assign in_pl                    = {ex_wreg_i, ex_hilo_i};
  assign {mem_wreg_o, mem_hilo_o} = out_pl;
  assign accept                   = in_valid & in_ready;
  assign deliver                  = out_valid & out_ready;

  generate
    if (SKID_EN != 0) begin : g_skid
      typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL2 = 2'd2
      } state_t;

      state_t        state_q;
      state_t        state_d;
      logic [PW-1:0] main_q;
      logic [PW-1:0] main_d;
      logic [PW-1:0] skid_q;
      logic [PW-1:0] skid_d;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q <= EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
        end
      end

      // Empty slots are always zeroed so a bubble presents we=0 to MEM.
      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end else begin
          case (state_q)
            EMPTY: begin
              if (accept) begin
                state_d = ONE;
                main_d  = in_pl;
              end
            end
            ONE: begin
              if (accept && deliver) begin
                main_d = in_pl;
              end else if (accept) begin
                state_d = FULL2;
                skid_d  = in_pl;
              end else if (deliver) begin
                state_d = EMPTY;
                main_d  = '0;
              end
            end
            FULL2: begin
              if (deliver) begin
                state_d = ONE;
                main_d  = skid_q;
                skid_d  = '0;
              end
            end
            default: begin
              state_d = EMPTY;
              main_d  = '0;
              skid_d  = '0;
            end
          endcase
        end
      end

      // in_ready comes straight from the state flop: no path from out_ready.
      assign in_ready  = (state_q != FULL2);
      assign out_valid = (state_q != EMPTY);
      assign out_pl    = main_q;
    end else begin : g_single
      logic          valid_q;
      logic [PW-1:0] data_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else if (flush) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else if (accept) begin
          valid_q <= 1'b1;
          data_q  <= in_pl;
        end else if (deliver) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end
      end

      assign in_ready  = ~valid_q | out_ready;
      assign out_valid = valid_q;
      assign out_pl    = data_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule
